dcache_dm_ctrl: RTL and testbench
=================================

Name: dcache_dm_ctrl

Overview:
- Clocked, parametrised direct-mapped data cache for the pipeline MEM stage, between the CPU load/store port and the backing data memory.
- Holds valid/tag/data per set, with byte-enable writes and a write-through, no-write-allocate policy.
- A controller FSM handles read-miss fill and memory writes over a req/ack handshake, and the block adds a multi-cycle flush and saturating hit/miss counters.

Parameters:
- ADDR_WIDTH, 32: byte address width.
- DATA_WIDTH, 32: word width; fixed 4 bytes per line, one word per line.
- SET_BITS, 3: index width; 2**SET_BITS sets.
- CNT_WIDTH, 16: width of the hit and miss counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  access request; held with stable addr/we/be/wdata until cpu_ready.
- cpu_we  in  1  1=store, 0=load.
- cpu_be  in  4  store byte enables; ignored on loads.
- cpu_addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored.
- cpu_wdata  in  DATA_WIDTH  store data.
- cpu_rdata  out  DATA_WIDTH  load data; valid when cpu_ready=1 and cpu_we=0.
- cpu_ready  out  1  access complete this cycle.
- flush  in  1  single-cycle pulse; invalidate all lines.
- flush_busy  out  1  flush pending or in progress.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_WIDTH  word-aligned address, bits [1:0]=0.
- mem_wdata  out  DATA_WIDTH  write data.
- mem_be  out  4  write byte enables.
- mem_rdata  in  DATA_WIDTH  read data; valid with mem_ack.
- mem_ack  in  1  memory completes the request this cycle.
- hit_cnt  out  CNT_WIDTH  load hit count, saturating.
- miss_cnt  out  CNT_WIDTH  load miss count, saturating.

Behaviour:
- Address fields:
  - index = cpu_addr[SET_BITS+1:2]
  - tag = cpu_addr[ADDR_WIDTH-1:SET_BITS+2]
  - hit = valid[index] and stored tag == tag
- Reset (async assert, sync release): all valid bits 0, FSM in IDLE, flush pending 0, counters 0. Outputs all 0: cpu_ready, mem_req, mem_we, mem_be, mem_addr, mem_wdata, cpu_rdata, flush_busy. Tag and data arrays are not reset.
- FSM states: IDLE, FILL, WRITE, FLUSH.
- IDLE:
  - Pending flush (latched, or flush=1 this cycle) has priority over cpu_req. Go to FLUSH, clear flush counter, cpu_ready=0.
  - Load hit: cpu_ready=1 combinationally in the same cycle, cpu_rdata = line data. hit_cnt++ at the edge. Stay IDLE.
  - Load miss: go FILL. miss_cnt++ at the edge.
  - Store: go WRITE; no lookup side-effects until the ack.
  - mem_ack in IDLE is ignored.
- FILL:
  - mem_req=1, mem_we=0, mem_addr={cpu_addr[ADDR_WIDTH-1:2],2'b00}.
  - On mem_ack: write line (valid=1, tag, data=mem_rdata). cpu_ready=1 and cpu_rdata=mem_rdata in the same cycle (bypass). Go IDLE.
  - Minimum load-miss latency is 2 cycles (ack in the first FILL cycle).
- WRITE:
  - mem_req=1, mem_we=1, mem_addr aligned, mem_wdata=cpu_wdata, mem_be=cpu_be.
  - On mem_ack: cpu_ready=1. If the line hit, merge the enabled bytes into the line data; valid and tag are unchanged. On a miss, no allocation. Go IDLE.
  - cpu_be=0 still performs the memory transaction; the line is unchanged.
- FLUSH:
  - Clears valid[k] for k = 0..2**SET_BITS-1, one set per cycle, so the state lasts exactly 2**SET_BITS cycles, then returns to IDLE.
  - cpu_ready=0 throughout.
  - flush_busy=1 from the cycle after the flush pulse until FLUSH exits.
- A flush pulse arriving in FILL or WRITE sets the pending flag (flush_busy=1). The current transaction completes normally; FLUSH then runs from the next IDLE cycle. Further pulses while pending or in FLUSH are absorbed; no restart.
- Counters stop at all-ones and do not wrap. Stores do not count.
- mem_req and mem_addr stay stable from request until ack; they deassert in the cycle after the ack.
- Reset mid-FILL or mid-WRITE: mem_req drops immediately; any later stale mem_ack is ignored in IDLE; the CPU must reissue.
- cpu_ready is never asserted without cpu_req.

Test Plan:
- Cold load 0x0000_0010, mem_ack after 3 cycles with rdata=0xDEADBEEF -> cpu_ready on the ack cycle, rdata=0xDEADBEEF, miss_cnt=1. Reload 0x10 -> cpu_ready same cycle, hit_cnt=1, no mem_req.
- Conflict: load 0x10, then 0x30 (same index 4, different tag), then 0x10 -> three misses, each with one mem_req at the correct aligned address.
- Store hit to 0x10, be=4'b0010, wdata=0x0000AB00, line=0xDEADBEEF -> mem_we=1 with be=0010. Later load hit returns 0xDEADABEF. Store miss to 0x50 followed by a load of 0x50 -> miss (no allocate).
- Flush pulse in IDLE with valid lines -> flush_busy for 8 cycles (SET_BITS=3), cpu_ready=0. Subsequent loads to previously cached addresses all miss.
- Flush pulse during FILL -> fill completes with cpu_ready, FLUSH follows immediately. Assert rst_n=0 mid-FILL -> mem_req=0 at once, counters 0; a late mem_ack produces no cpu_ready.
- Drive 2**CNT_WIDTH+5 load hits (CNT_WIDTH=4) -> hit_cnt saturates at 15.

Source files
------------

// File: rtl/dcache_dm_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache for the MEM stage.
// One 32-bit word per line. A four-state controller (IDLE/FILL/WRITE/FLUSH)
// drives the backing-memory req/ack port. The block also provides a
// multi-cycle flush and saturating load hit/miss counters.
//
// Handshakes:
//   cpu: cpu_req is held with stable address, we, be and wdata until
//        cpu_ready. A load hit completes in the same cycle.
//   mem: mem_req, mem_addr, mem_we, mem_wdata and mem_be are held until
//        mem_ack. mem_rdata is sampled only with mem_ack. The request
//        drops in the cycle after the ack.
module dcache_dm_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SET_BITS   = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [3:0]            cpu_be,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ready,
  input  logic                  flush,
  output logic                  flush_busy,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic [CNT_WIDTH-1:0]  hit_cnt,
  output logic [CNT_WIDTH-1:0]  miss_cnt
);

  localparam int SETS  = 1 << SET_BITS;
  localparam int TAG_W = ADDR_WIDTH - SET_BITS - 2;
  localparam logic [SET_BITS-1:0]  LAST_SET = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_FLUSH} state_t;

  state_t                state_q, state_d;
  logic [SETS-1:0]       valid_q, valid_d;
  logic                  flush_pend_q, flush_pend_d;
  logic [SET_BITS-1:0]   flush_cnt_q, flush_cnt_d;
  logic [CNT_WIDTH-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0]  miss_cnt_q, miss_cnt_d;

  // Tag and data arrays carry no reset; valid_q alone qualifies them.
  logic [TAG_W-1:0]      tag_q  [SETS];
  logic [DATA_WIDTH-1:0] data_q [SETS];

  logic                  line_we;
  logic [DATA_WIDTH-1:0] line_wdata;
  logic [DATA_WIDTH-1:0] merged;
  logic [SET_BITS-1:0]   index;
  logic [TAG_W-1:0]      tag;
  logic [DATA_WIDTH-1:0] line_data;
  logic                  hit;
  logic [1:0]            unused_addr_lsb;

  assign index           = cpu_addr[SET_BITS+1:2];
  assign tag             = cpu_addr[ADDR_WIDTH-1:SET_BITS+2];
  assign line_data       = data_q[index];
  assign hit             = valid_q[index] && (tag_q[index] == tag);
  assign unused_addr_lsb = cpu_addr[1:0];
  assign flush_busy      = flush_pend_q || (state_q == S_FLUSH);
  assign hit_cnt         = hit_cnt_q;
  assign miss_cnt        = miss_cnt_q;

  // Store-hit merge: the enabled bytes take the store data, the rest keep the line.
  always_comb begin
    merged = line_data;
    for (int b = 0; b < 4; b++) begin
      if (cpu_be[b]) merged[8*b +: 8] = cpu_wdata[8*b +: 8];
    end
  end

  // Controller next-state, bookkeeping and all port outputs.
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    flush_pend_d = flush_pend_q;
    flush_cnt_d  = flush_cnt_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    line_we      = 1'b0;
    line_wdata   = mem_rdata;
    cpu_ready    = 1'b0;
    cpu_rdata    = '0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_be       = '0;
    case (state_q)
      S_IDLE: begin
        if (flush_pend_q || flush) begin
          state_d      = S_FLUSH;
          flush_cnt_d  = '0;
          flush_pend_d = 1'b0;
        end else if (cpu_req) begin
          if (cpu_we) begin
            state_d = S_WRITE;
          end else if (hit) begin
            cpu_ready = 1'b1;
            cpu_rdata = line_data;
            if (hit_cnt_q != CNT_MAX) hit_cnt_d = hit_cnt_q + CNT_WIDTH'(1);
          end else begin
            state_d = S_FILL;
            if (miss_cnt_q != CNT_MAX) miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
          end
        end
      end
      S_FILL: begin
        if (flush) flush_pend_d = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
        if (mem_ack) begin
          line_we        = 1'b1;
          line_wdata     = mem_rdata;
          valid_d[index] = 1'b1;
          cpu_ready      = cpu_req;
          cpu_rdata      = mem_rdata;
          state_d        = S_IDLE;
        end
      end
      S_WRITE: begin
        if (flush) flush_pend_d = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
        mem_wdata = cpu_wdata;
        mem_be    = cpu_be;
        if (mem_ack) begin
          cpu_ready = cpu_req;
          if (hit) begin
            line_we    = 1'b1;
            line_wdata = merged;
          end
          state_d = S_IDLE;
        end
      end
      S_FLUSH: begin
        valid_d[flush_cnt_q] = 1'b0;
        flush_cnt_d          = flush_cnt_q + SET_BITS'(1);
        if (flush_cnt_q == LAST_SET) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Controller and bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      flush_pend_q <= 1'b0;
      flush_cnt_q  <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      flush_pend_q <= flush_pend_d;
      flush_cnt_q  <= flush_cnt_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  // Line storage write port. A fill writes tag and data; a store hit rewrites
  // the same tag with the merged data.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[index]  <= tag;
      data_q[index] <= line_wdata;
    end
  end

endmodule

// File: tb/tb_dcache_dm_ctrl.sv
// Directed bench for dcache_dm_ctrl (SET_BITS=3, CNT_WIDTH=4).
module tb_dcache_dm_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [3:0]  cpu_be = '0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        flush = 1'b0;
  logic        flush_busy;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [3:0]  hit_cnt;
  logic [3:0]  miss_cnt;

  int total = 0;
  int bad   = 0;

  dcache_dm_ctrl #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .SET_BITS(3), .CNT_WIDTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .flush(flush), .flush_busy(flush_busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_miss(input logic [31:0] a, input int nwait, input logic [31:0] d);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    #1;
    chk("miss_idle_ready", {31'b0, cpu_ready}, 32'd0);
    chk("miss_idle_req", {31'b0, mem_req}, 32'd0);
    tick;
    for (int i = 0; i < nwait; i++) begin
      #1;
      chk("fill_req", {31'b0, mem_req}, 32'd1);
      chk("fill_we", {31'b0, mem_we}, 32'd0);
      chk("fill_addr", mem_addr, a & 32'hFFFF_FFFC);
      chk("fill_wait_ready", {31'b0, cpu_ready}, 32'd0);
      tick;
    end
    mem_ack = 1'b1; mem_rdata = d;
    #1;
    chk("fill_ack_addr", mem_addr, a & 32'hFFFF_FFFC);
    chk("fill_ack_ready", {31'b0, cpu_ready}, 32'd1);
    chk("fill_ack_rdata", cpu_rdata, d);
    tick;
    cpu_req = 1'b0; mem_ack = 1'b0;
    #1;
    chk("fill_req_drop", {31'b0, mem_req}, 32'd0);
  endtask

  task automatic load_hit(input logic [31:0] a, input logic [31:0] d);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    #1;
    chk("hit_ready", {31'b0, cpu_ready}, 32'd1);
    chk("hit_rdata", cpu_rdata, d);
    chk("hit_no_req", {31'b0, mem_req}, 32'd0);
    tick;
    cpu_req = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                       input int nwait);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_be = be; cpu_wdata = wd;
    #1;
    chk("st_idle_ready", {31'b0, cpu_ready}, 32'd0);
    tick;
    for (int i = 0; i < nwait; i++) begin
      #1;
      chk("st_req", {31'b0, mem_req}, 32'd1);
      chk("st_we", {31'b0, mem_we}, 32'd1);
      chk("st_addr", mem_addr, a & 32'hFFFF_FFFC);
      chk("st_wdata", mem_wdata, wd);
      chk("st_wait_ready", {31'b0, cpu_ready}, 32'd0);
      tick;
    end
    mem_ack = 1'b1;
    #1;
    chk("st_ack_we", {31'b0, mem_we}, 32'd1);
    chk("st_ack_be", {28'b0, mem_be}, {28'b0, be});
    chk("st_ack_ready", {31'b0, cpu_ready}, 32'd1);
    tick;
    cpu_req = 1'b0; cpu_we = 1'b0; mem_ack = 1'b0;
    #1;
    chk("st_req_drop", {31'b0, mem_req}, 32'd0);
  endtask

  // Directed sequence
  initial begin
    // Reset state
    #2;
    chk("rst_ready", {31'b0, cpu_ready}, 32'd0);
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_busy", {31'b0, flush_busy}, 32'd0);
    chk("rst_hit", {28'b0, hit_cnt}, 32'd0);
    chk("rst_miss", {28'b0, miss_cnt}, 32'd0);
    tick; tick;
    rst_n = 1'b1;
    tick;

    // Cold load then reload
    load_miss(32'h10, 2, 32'hDEAD_BEEF);
    chk("cold_miss_cnt", {28'b0, miss_cnt}, 32'd1);
    chk("cold_hit_cnt", {28'b0, hit_cnt}, 32'd0);
    load_hit(32'h10, 32'hDEAD_BEEF);
    #1;
    chk("reload_hit_cnt", {28'b0, hit_cnt}, 32'd1);

    // Conflict on index 4
    load_miss(32'h30, 1, 32'h1111_2222);
    load_miss(32'h10, 1, 32'hDEAD_BEEF);
    chk("conflict_miss_cnt", {28'b0, miss_cnt}, 32'd3);

    // Store hit with a single byte enable, then read the merged line
    store(32'h10, 4'b0010, 32'h0000_AB00, 1);
    load_hit(32'h10, 32'hDEAD_ABEF);
    // Store miss does not allocate
    store(32'h50, 4'b1111, 32'h1234_5678, 0);
    load_miss(32'h50, 0, 32'h5555_0000);
    load_hit(32'h50, 32'h5555_0000);
    load_miss(32'h04, 0, 32'h0404_0404);
    load_hit(32'h04, 32'h0404_0404);
    #1;
    chk("pre_flush_hit_cnt", {28'b0, hit_cnt}, 32'd4);
    chk("pre_flush_miss_cnt", {28'b0, miss_cnt}, 32'd5);

    // Flush from IDLE, a load held during the flush
    flush = 1'b1;
    #1;
    chk("flush_pulse_busy", {31'b0, flush_busy}, 32'd0);
    tick;
    flush = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h04;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("flush_busy", {31'b0, flush_busy}, 32'd1);
      chk("flush_no_ready", {31'b0, cpu_ready}, 32'd0);
      tick;
    end
    #1;
    chk("flush_done_busy", {31'b0, flush_busy}, 32'd0);
    load_miss(32'h04, 0, 32'h0404_0404);
    load_miss(32'h50, 1, 32'h5555_0000);
    chk("post_flush_miss_cnt", {28'b0, miss_cnt}, 32'd7);

    // Flush pulse during a fill
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h08;
    #1;
    tick;
    flush = 1'b1;
    #1;
    chk("ff_req", {31'b0, mem_req}, 32'd1);
    chk("ff_addr", mem_addr, 32'h08);
    chk("ff_busy_pulse", {31'b0, flush_busy}, 32'd0);
    tick;
    flush = 1'b0;
    #1;
    chk("ff_busy_pend", {31'b0, flush_busy}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h0808_0808;
    #1;
    chk("ff_ready", {31'b0, cpu_ready}, 32'd1);
    chk("ff_rdata", cpu_rdata, 32'h0808_0808);
    tick;
    cpu_req = 1'b0; mem_ack = 1'b0;
    #1;
    chk("ff_idle_busy", {31'b0, flush_busy}, 32'd1);
    chk("ff_idle_req", {31'b0, mem_req}, 32'd0);
    tick;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("ff_flush_busy", {31'b0, flush_busy}, 32'd1);
      tick;
    end
    #1;
    chk("ff_done_busy", {31'b0, flush_busy}, 32'd0);
    chk("ff_miss_cnt", {28'b0, miss_cnt}, 32'd8);

    // Reset in the middle of a fill
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0C;
    #1;
    tick;
    #1;
    chk("rf_req_before", {31'b0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rf_req_drop", {31'b0, mem_req}, 32'd0);
    chk("rf_hit_cnt", {28'b0, hit_cnt}, 32'd0);
    chk("rf_miss_cnt", {28'b0, miss_cnt}, 32'd0);
    chk("rf_ready", {31'b0, cpu_ready}, 32'd0);
    tick;
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h0C0C_0C0C;
    #1;
    chk("rf_stale_ack_ready", {31'b0, cpu_ready}, 32'd0);
    chk("rf_stale_ack_req", {31'b0, mem_req}, 32'd0);
    tick;
    #1;
    chk("rf_reissue_ready", {31'b0, cpu_ready}, 32'd1);
    chk("rf_reissue_rdata", cpu_rdata, 32'h0C0C_0C0C);
    chk("rf_reissue_miss", {28'b0, miss_cnt}, 32'd1);
    tick;
    cpu_req = 1'b0; mem_ack = 1'b0;

    // 21 back-to-back load hits saturate the 4-bit hit counter
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0C;
    for (int i = 0; i < 21; i++) begin
      #1;
      chk("sat_ready", {31'b0, cpu_ready}, 32'd1);
      chk("sat_cnt", {28'b0, hit_cnt}, (i < 15) ? i : 15);
      tick;
    end
    cpu_req = 1'b0;
    #1;
    chk("sat_final", {28'b0, hit_cnt}, 32'd15);
    chk("sat_miss", {28'b0, miss_cnt}, 32'd1);

    // Store with no byte enables leaves the line unchanged
    store(32'h0C, 4'b0000, 32'hFFFF_FFFF, 0);
    load_hit(32'h0C, 32'h0C0C_0C0C);
    #1;
    chk("sat_hold", {28'b0, hit_cnt}, 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
